// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default product width and a two's-complement helper.
package seq_shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int PROD_W        = 2 * DEFAULT_WIDTH;

  // Widest value the helper handles; callers zero-extend into it and truncate back.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] val,
                                                   input logic             neg);
    return neg ? (~val + MAX_W'(1)) : val;
  endfunction

endpackage

// File: rtl/ripple_adder_16.sv
// 16-bit ripple-carry adder: two 8-bit stages with the carry rippling between them.
module ripple_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic carry_mid;

  ripple_adder_8 u_lo (.a(a[7:0]),  .b(b[7:0]),  .cin(cin),       .sum(sum[7:0]),  .cout(carry_mid));
  ripple_adder_8 u_hi (.a(a[15:8]), .b(b[15:8]), .cin(carry_mid), .sum(sum[15:8]), .cout(cout));

endmodule

// File: rtl/ripple_adder_4.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/ripple_adder_8.sv
// 8-bit ripple-carry adder: two 4-bit stages with the carry rippling between them.
module ripple_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic carry_mid;

  ripple_adder_4 u_lo (.a(a[3:0]), .b(b[3:0]), .cin(cin),       .sum(sum[3:0]), .cout(carry_mid));
  ripple_adder_4 u_hi (.a(a[7:4]), .b(b[7:4]), .cin(carry_mid), .sum(sum[7:4]), .cout(cout));

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential shift-and-add multiplier: one ripple add per cycle, WIDTH cycles,
// optional sign-magnitude handling, start/ready/done handshake with a held product.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [PW-1:0]    res;

  assign addend = mplr_q[0] ? mcand_q : '0;

  if (WIDTH == 16) begin : g_add16
    ripple_adder_16 u_add (
      .a(acc_hi_q), .b(addend), .cin(1'b0), .sum(add_sum), .cout(add_cout)
    );
  end else if (WIDTH % 8 == 0) begin : g_add8
    localparam int N = WIDTH / 8;
    logic [N:0] carry;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_slice
      ripple_adder_8 u_add (
        .a(acc_hi_q[8*i +: 8]), .b(addend[8*i +: 8]), .cin(carry[i]),
        .sum(add_sum[8*i +: 8]), .cout(carry[i+1])
      );
    end
    assign add_cout = carry[N];
  end else if (WIDTH % 4 == 0) begin : g_add4
    localparam int N = WIDTH / 4;
    logic [N:0] carry;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_slice
      ripple_adder_4 u_add (
        .a(acc_hi_q[4*i +: 4]), .b(addend[4*i +: 4]), .cin(carry[i]),
        .sum(add_sum[4*i +: 4]), .cout(carry[i+1])
      );
    end
    assign add_cout = carry[N];
  end else begin : g_add_beh
    assign {add_cout, add_sum} = {1'b0, acc_hi_q} + {1'b0, addend};
  end

  // NOTE: every variable gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    neg_d     = neg_q;
    product_d = product_q;
    res       = PW'(cond_negate(MAX_W'({acc_hi_q, mplr_q}), neg_q));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = WIDTH'(cond_negate(MAX_W'(in1), SIGNED & in1[WIDTH-1]));
          mplr_d   = WIDTH'(cond_negate(MAX_W'(in2), SIGNED & in2[WIDTH-1]));
          neg_d    = SIGNED & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry-out becomes the new MSB of acc_hi; the LSB of the sum shifts into mplr.
        acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
        mplr_d   = {add_sum[0], mplr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        product_d = res;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers here are
  // small control/datapath flops, so every one of them is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_hi_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == CALC) || (state_q == FIX);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: an unsigned and a signed instance of the multiplier checked
// against plain integer multiplication, plus handshake, abort and hold scenarios.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_u = 1'b0, start_s = 1'b0;
  logic [15:0] in1_u = '0, in2_u = '0, in1_s = '0, in2_s = '0;
  logic        ready_u, busy_u, done_u, ready_s, busy_s, done_s;
  logic [31:0] product_u, product_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(16), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .in1(in1_u), .in2(in2_u),
    .ready(ready_u), .busy(busy_u), .done(done_u), .product(product_u)
  );

  seq_shift_add_multiplier #(.WIDTH(16), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .in1(in1_s), .in2(in2_s),
    .ready(ready_s), .busy(busy_s), .done(done_s), .product(product_s)
  );

  // Reference: ordinary integer multiply, sign-extended operands when signed.
  function automatic logic [31:0] model_mul(input bit sgn, input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    p = x * y;
    return p[31:0];
  endfunction

  task automatic drive(input bit sgn, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (sgn) begin start_s = st; in1_s = a; in2_s = b; end
    else     begin start_u = st; in1_u = a; in2_u = b; end
  endtask

  function automatic logic get_done(input bit sgn);  return sgn ? done_s  : done_u;  endfunction
  function automatic logic get_busy(input bit sgn);  return sgn ? busy_s  : busy_u;  endfunction
  function automatic logic get_ready(input bit sgn); return sgn ? ready_s : ready_u; endfunction
  function automatic logic [31:0] get_prod(input bit sgn); return sgn ? product_s : product_u; endfunction

  // One operation; edges counts rising edges from the sampling edge through the one raising done.
  task automatic run_op(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int edges, output int busy_n,
                        output int rdy_low_n, output bit timed_out);
    edges = 0; busy_n = 0; rdy_low_n = 0; timed_out = 1'b1; prod = '0;
    @(negedge clk);
    drive(sgn, 1'b1, a, b);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drive(sgn, 1'b0, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      if (get_busy(sgn))   busy_n++;
      if (!get_ready(sgn)) rdy_low_n++;
      if (get_done(sgn)) begin
        prod = get_prod(sgn);
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_u !== 1'b1 || busy_u !== 1'b0 || done_u !== 1'b0 || product_u !== 32'd0) begin
      errors++;
      $display("FAIL reset_u: ready=%b busy=%b done=%b product=%h, want 1 0 0 00000000", ready_u, busy_u, done_u, product_u);
    end
    checks++;
    if (ready_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || product_s !== 32'd0) begin
      errors++;
      $display("FAIL reset_s: ready=%b busy=%b done=%b product=%h, want 1 0 0 00000000", ready_s, busy_s, done_s, product_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [31:0] p; int e, bn, rn; bit to;
    run_op(1'b0, 16'd3, 16'd5, p, e, bn, rn, to);
    checks++;
    if (to || p !== 32'h0000000F) begin
      errors++; $display("FAIL lat_product: got %h timeout=%0d, want 0000000f", p, to);
    end
    checks++;
    if (e !== 18) begin errors++; $display("FAIL lat_edges: got %0d, want 18", e); end
    checks++;
    if (bn !== 17) begin errors++; $display("FAIL lat_busy_cycles: got %0d, want 17", bn); end
    checks++;
    if (rn !== 18) begin errors++; $display("FAIL lat_ready_low: got %0d, want 18", rn); end
    @(negedge clk);
    checks++;
    if (done_u !== 1'b0 || ready_u !== 1'b1 || product_u !== 32'h0000000F) begin
      errors++;
      $display("FAIL lat_after_done: done=%b ready=%b product=%h, want 0 1 0000000f", done_u, ready_u, product_u);
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [5] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h0000, 16'h0000};
    logic [15:0] db [5] = '{16'hFFFF, 16'h0005, 16'h8000, 16'h8000, 16'hFFFF};
    bit          ds [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] de [5] = '{32'hFFFE0001, 32'hFFFFFFF1, 32'h40000000, 32'h0, 32'h0};
    logic [31:0] p; int e, bn, rn; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ds[i], da[i], db[i], p, e, bn, rn, to);
      checks++;
      if (to || p !== de[i]) begin
        errors++;
        $display("FAIL directed_%0d: %h*%h signed=%0d got %h timeout=%0d, want %h", i, da[i], db[i], ds[i], p, to, de[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] p, exp; logic [15:0] a, b; int e, bn, rn; bit to; bit sgn;
    for (int i = 0; i < 24; i++) begin
      sgn = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 8 == 2) a = 16'h8000;
      exp = model_mul(sgn, a, b);
      run_op(sgn, a, b, p, e, bn, rn, to);
      checks++;
      if (to || p !== exp || e !== 18) begin
        errors++;
        $display("FAIL random_%0d: %h*%h signed=%0d got %h edges=%0d, want %h edges=18", i, a, b, sgn, p, e, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] got = '0; bit seen = 1'b0; int stray = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd11, 16'd13);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_u) begin
        got = product_u; seen = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        break;
      end
      drive(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    end
    checks++;
    if (!seen || got !== model_mul(1'b0, 16'd11, 16'd13)) begin
      errors++; $display("FAIL ignore_start_result: got %h seen=%0d, want %h", got, seen, model_mul(1'b0, 16'd11, 16'd13));
    end
    repeat (3) begin
      @(negedge clk);
      if (busy_u || !ready_u) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL ignore_start_queued: %0d busy cycles, want 0", stray); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p; int e, bn, rn; bit to;
    run_op(1'b0, 16'd7, 16'd9, p, e, bn, rn, to);
    checks++;
    if (to || p !== 32'h3F) begin errors++; $display("FAIL b2b_first: got %h, want 0000003f", p); end
    run_op(1'b0, 16'd2, 16'd4, p, e, bn, rn, to);
    checks++;
    if (to || p !== 32'h8 || e !== 18) begin
      errors++; $display("FAIL b2b_second: got %h edges=%0d, want 00000008 edges=18", p, e);
    end
  endtask

  task automatic test_abort();
    logic [31:0] p; int e, bn, rn; bit to; int done_seen = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h1234, 16'h5678);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (product_u !== 32'd0 || ready_u !== 1'b1 || busy_u !== 1'b0 || done_u !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: product=%h ready=%b busy=%b done=%b, want 00000000 1 0 0", product_u, ready_u, busy_u, done_u);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_u) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: %0d done cycles, want 0", done_seen); end
    run_op(1'b0, 16'd6, 16'd7, p, e, bn, rn, to);
    checks++;
    if (to || p !== 32'h2A) begin errors++; $display("FAIL abort_recover: got %h, want 0000002a", p); end
  endtask

  task automatic test_hold();
    logic [31:0] exp; bit seen = 1'b0;
    exp = model_mul(1'b0, 16'hABCD, 16'h1111);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'hABCD, 16'h1111);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'd0, 16'd0);
      if (done_u) begin seen = 1'b1; break; end
      checks++;
      if (product_u !== 32'h2A) begin
        errors++; $display("FAIL hold_cycle_%0d: product=%h, want 0000002a", i, product_u);
      end
    end
    checks++;
    if (!seen || product_u !== exp) begin
      errors++; $display("FAIL hold_update: product=%h seen=%0d, want %h", product_u, seen, exp);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
